// File: rtl/decoder_2x4_pipe_if.sv
// Handshake bus for the pipelined 2-to-4 decoder: input stream, one-hot output stream
// and decode-counter readback.
interface decoder_2x4_pipe_if #(
    parameter int unsigned CNT_W = 8
);
    logic             en;
    logic [1:0]       in_code;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       out_onehot;
    logic             out_valid;
    logic             out_ready;
    logic             clr_cnt;
    logic [1:0]       cnt_sel;
    logic [CNT_W-1:0] cnt_val;

    modport master (
        output en, in_code, in_valid, out_ready, clr_cnt, cnt_sel,
        input  in_ready, out_onehot, out_valid, cnt_val
    );

    modport slave (
        input  en, in_code, in_valid, out_ready, clr_cnt, cnt_sel,
        output in_ready, out_onehot, out_valid, cnt_val
    );
endinterface

// File: rtl/decoder_2x4_pipe.sv
// 2-to-4 decoder behind a small ready/valid FIFO, with saturating per-line decode
// counters and registered counter readback.
module decoder_2x4_pipe #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    decoder_2x4_pipe_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [1:0]       mem [DEPTH];
    logic [CNT_W-1:0] cnt [4];
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic [3:0]       head_onehot;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);

    assign bus.in_ready = rst_n && bus.en && !full;
    assign push         = bus.in_valid && bus.in_ready;
    assign pop          = !empty && bus.out_ready;

    // Code 2'b00 maps to the MSB line, 2'b11 to the LSB line.
    always_comb begin
        head_onehot = 4'b1000 >> mem[rd_ptr[AW-1:0]];
    end

    assign bus.out_valid  = !empty;
    assign bus.out_onehot = empty ? 4'b0000 : head_onehot;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Storage needs no reset; pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= bus.in_code;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else if (bus.clr_cnt) begin
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else if (pop) begin
            for (int i = 0; i < 4; i++) begin
                if (head_onehot[i] && (cnt[i] != {CNT_W{1'b1}}))
                    cnt[i] <= cnt[i] + CNT_W'(1);
            end
        end
    end

    // Readback samples the pre-update counter value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bus.cnt_val <= '0;
        else        bus.cnt_val <= cnt[bus.cnt_sel];
    end
endmodule

// File: tb/tb_decoder_2x4_pipe.sv
// Directed bench for decoder_2x4_pipe with a queue scoreboard and a cycle model of
// occupancy, counters and readback.
module tb_decoder_2x4_pipe;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned CNT_W = 2;
    localparam int          CMAX  = 3;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    logic [3:0] sb_q [$];
    int         m_cnt [4];
    int         m_cnt_val;

    decoder_2x4_pipe_if #(.CNT_W(CNT_W)) bus ();

    decoder_2x4_pipe #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [3:0] dec(input logic [1:0] c);
        case (c)
            2'b11:   dec = 4'b0001;
            2'b10:   dec = 4'b0010;
            2'b01:   dec = 4'b0100;
            default: dec = 4'b1000;
        endcase
    endfunction

    function automatic int line_idx(input logic [3:0] oh);
        line_idx = 0;
        for (int i = 0; i < 4; i++) if (oh[i]) line_idx = i;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        sb_q.delete();
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        m_cnt_val = 0;
    endtask

    // One clock: drive at negedge, check against the model, then advance model and DUT.
    task automatic cycle(input logic e, input logic v, input logic [1:0] c,
                         input logic r, input logic clr, input logic [1:0] sel);
        logic       m_ready;
        logic       m_push;
        logic       m_pop;
        logic [3:0] head;
        bus.en = e; bus.in_valid = v; bus.in_code = c;
        bus.out_ready = r; bus.clr_cnt = clr; bus.cnt_sel = sel;
        #1;
        m_ready = e && (sb_q.size() < DEPTH);
        head    = (sb_q.size() > 0) ? sb_q[0] : 4'b0000;
        chk("in_ready",   8'(bus.in_ready),   8'(m_ready));
        chk("out_valid",  8'(bus.out_valid),  8'(sb_q.size() > 0));
        chk("out_onehot", 8'(bus.out_onehot), 8'(head));
        chk("cnt_val",    8'(bus.cnt_val),    8'(m_cnt_val));
        m_push    = v && m_ready;
        m_pop     = (sb_q.size() > 0) && r;
        m_cnt_val = m_cnt[sel];
        if (clr) begin
            for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        end else if (m_pop && m_cnt[line_idx(head)] < CMAX) begin
            m_cnt[line_idx(head)]++;
        end
        if (m_pop)  void'(sb_q.pop_front());
        if (m_push) sb_q.push_back(dec(c));
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        model_reset();
        rst_n = 1'b0;
        bus.en = 1'b1; bus.in_valid = 1'b0; bus.in_code = 2'b00;
        bus.out_ready = 1'b0; bus.clr_cnt = 1'b0; bus.cnt_sel = 2'b00;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_in_ready",   8'(bus.in_ready),   8'h0);
        chk("rst_out_valid",  8'(bus.out_valid),  8'h0);
        chk("rst_out_onehot", 8'(bus.out_onehot), 8'h0);
        chk("rst_cnt_val",    8'(bus.cnt_val),    8'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single push held with out_ready low, then released.
        cycle(1, 1, 2'b11, 0, 0, 0);
        cycle(1, 0, 2'b00, 0, 0, 0);
        cycle(1, 0, 2'b00, 0, 0, 0);
        chk("hold_onehot", 8'(bus.out_onehot), 8'h01);
        cycle(1, 0, 2'b00, 1, 0, 0);
        chk("after_pop_valid", 8'(bus.out_valid), 8'h0);

        // Fill to full, third input ignored, then pop on full with in_valid high.
        cycle(1, 1, 2'b10, 0, 0, 0);
        cycle(1, 1, 2'b01, 0, 0, 0);
        chk("full_in_ready", 8'(bus.in_ready), 8'h0);
        cycle(1, 1, 2'b00, 0, 0, 0);
        chk("full_head", 8'(bus.out_onehot), 8'h02);
        cycle(1, 1, 2'b11, 1, 0, 0);
        chk("freed_in_ready", 8'(bus.in_ready), 8'h1);
        chk("second_head",    8'(bus.out_onehot), 8'h04);
        cycle(1, 1, 2'b11, 1, 0, 0);
        chk("third_head", 8'(bus.out_onehot), 8'h01);
        cycle(1, 0, 2'b00, 1, 0, 0);
        cycle(1, 0, 2'b00, 1, 0, 0);

        // en low: buffered entry still drains, new input blocked.
        cycle(1, 1, 2'b01, 0, 0, 0);
        cycle(0, 1, 2'b10, 0, 0, 0);
        chk("en_low_hold", 8'(bus.out_onehot), 8'h04);
        cycle(0, 1, 2'b10, 1, 0, 0);
        cycle(1, 0, 2'b00, 1, 0, 0);

        // Saturation with a 2-bit counter on line 3.
        cycle(1, 0, 2'b00, 0, 1, 3);
        for (int k = 0; k < 5; k++) cycle(1, 1, 2'b00, 1, 0, 3);
        cycle(1, 0, 2'b00, 1, 0, 3);
        cycle(1, 0, 2'b00, 1, 0, 3);
        chk("sat_cnt3", 8'(bus.cnt_val), 8'h3);
        cycle(1, 1, 2'b00, 0, 0, 3);
        cycle(1, 0, 2'b00, 1, 1, 3);
        cycle(1, 0, 2'b00, 0, 0, 3);
        chk("clr_prio_cnt3", 8'(bus.cnt_val), 8'h0);

        // Stream all four codes back-to-back, then read every counter.
        cycle(1, 0, 2'b00, 0, 1, 0);
        cycle(1, 1, 2'b11, 1, 0, 0);
        cycle(1, 1, 2'b10, 1, 0, 0);
        cycle(1, 1, 2'b01, 1, 0, 0);
        cycle(1, 1, 2'b00, 1, 0, 0);
        cycle(1, 0, 2'b00, 1, 0, 0);
        chk("idle_onehot", 8'(bus.out_onehot), 8'h0);
        for (int s = 0; s < 4; s++) begin
            cycle(1, 0, 2'b00, 1, 0, 2'(s));
            cycle(1, 0, 2'b00, 1, 0, 2'(s));
            chk("stream_cnt", 8'(bus.cnt_val), 8'h1);
        end

        // Reset with two entries buffered and out_ready high.
        cycle(1, 1, 2'b01, 0, 0, 2);
        cycle(1, 1, 2'b10, 0, 0, 2);
        bus.out_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid",  8'(bus.out_valid),  8'h0);
        chk("midrst_out_onehot", 8'(bus.out_onehot), 8'h0);
        chk("midrst_in_ready",   8'(bus.in_ready),   8'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int s = 0; s < 4; s++) begin
            cycle(1, 0, 2'b00, 1, 0, 2'(s));
            cycle(1, 0, 2'b00, 1, 0, 2'(s));
            chk("post_rst_cnt", 8'(bus.cnt_val), 8'h0);
        end
        chk("post_rst_valid", 8'(bus.out_valid), 8'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/decoder_2x4_pipe.md
DECODER_2X4_PIPE -- requirements
Module: decoder_2x4_pipe

Interface
REQ-001 Parameter DEPTH, default 2, buffer depth in entries (power of two, >= 2).
REQ-002 Parameter CNT_W, default 8, width of each per-line decode counter.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 en  input  1  accept enable; low blocks new input, drain continues.
REQ-006 in_code  input  2  binary code to decode.
REQ-007 in_valid  input  1  in_code valid.
REQ-008 in_ready  output  1  block can accept in_code this cycle.
REQ-009 out_onehot  output  4  decoded one-hot line.
REQ-010 out_valid  output  1  out_onehot valid.
REQ-011 out_ready  input  1  sink accepts out_onehot this cycle.
REQ-012 clr_cnt  input  1  synchronous clear of all decode counters.
REQ-013 cnt_sel  input  2  selects counter for readback.
REQ-014 cnt_val  output  CNT_W  registered value of selected counter.

Function
REQ-015 Decode map SHALL be: 2'b11 -> 4'b0001, 2'b10 -> 4'b0010, 2'b01 -> 4'b0100, 2'b00 -> 4'b1000 (exact inverse of the team's 4x2 encoder).
REQ-016 Push SHALL occur when in_valid && in_ready; pushed code stored at FIFO tail.
REQ-017 in_ready SHALL equal en && !full, combinational from registered state only (no dependence on out_ready).
REQ-018 out_valid SHALL equal !empty; out_onehot SHALL be decode(head) when out_valid, 4'b0000 otherwise.
REQ-019 Pop SHALL occur when out_valid && out_ready.
REQ-020 Latency push-to-out_valid SHALL be exactly 1 cycle; no combinational in->out bypass.
REQ-021 Simultaneous push and pop with 0 < occupancy < DEPTH SHALL keep occupancy unchanged and preserve order.
REQ-022 When full, in_ready SHALL be 0 even if pop occurs same cycle; the freed slot becomes available next cycle.
REQ-023 When empty, no pop SHALL occur; an out_ready held high causes no state change.
REQ-024 Read/write pointers SHALL be log2(DEPTH)+1 bits, wrapping modulo 2*DEPTH; full = MSBs differ and LSBs equal, empty = pointers equal.
REQ-025 out_onehot SHALL hold stable while out_valid && !out_ready.
REQ-026 Counter i (i = one-hot bit index) SHALL increment by 1 on each pop whose out_onehot bit i is set.
REQ-027 Counters SHALL saturate at 2^CNT_W-1; no wrap.
REQ-028 clr_cnt SHALL zero all four counters next edge and take priority over a same-cycle increment.
REQ-029 cnt_val SHALL equal counter[cnt_sel] as sampled at the previous edge (1-cycle readback latency, post-update value excluded).
REQ-030 en low SHALL not flush the buffer; stored entries drain normally.
REQ-031 Exactly one out_onehot bit SHALL be high whenever out_valid is 1.

Reset
REQ-032 On rst_n low: pointers cleared (empty), out_valid 0, out_onehot 4'b0000, in_ready 0 while rst_n low, all counters 0, cnt_val 0.
REQ-033 Reset asserted mid-transfer SHALL discard all buffered entries; no partial pop recorded in counters.
REQ-034 After rst_n deassert, in_ready SHALL follow REQ-017 from the first edge.

Verification
REQ-035 Reset, en=1, push 2'b11 with out_ready=0 -> next cycle out_valid=1, out_onehot=4'b0001; holds until out_ready=1.
REQ-036 DEPTH=2, out_ready=0, push 2'b10 then 2'b01 -> in_ready=0 after 2nd push; third in_valid ignored; drain yields 4'b0010 then 4'b0100.
REQ-037 Full buffer, in_valid=1, out_ready=1 -> pop occurs, no push that cycle, push accepted next cycle; order preserved.
REQ-038 CNT_W=2, push/pop 2'b00 five times, cnt_sel=3 -> cnt_val saturates at 3; clr_cnt=1 with simultaneous pop of 2'b00 -> counter 0.
REQ-039 Stream all four codes back-to-back with out_ready=1 -> one-hot sequence matches REQ-015, each counter = 1, out_onehot 0 when idle.
REQ-040 Assert rst_n=0 with 2 entries buffered -> out_valid=0, out_onehot=0, all cnt_val reads 0 after release.
